fn_sw_4_ident: RTL and testbench
================================

Name: fn_sw_4_ident

Overview:
- Identifier for the 4-function logic selector (sel 00=AND, 01=OR, 10=XOR, 11=XNOR).
- It is the stimulus/readback side of that block: it drives a and b through all four input combinations and reads y back.
- It eliminates candidate functions on mismatch and reports the recovered 2-bit sel code.
- Used in self-check benches and board bring-up to confirm which function a selector instance implements.

Parameters:
- SETTLE, 1: idle cycles between driving a_o/b_o and sampling y_i; range 0..15; SETTLE=0 requires combinational y_i.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request an identification run; accepted only in IDLE
- a_o  out  1  stimulus to selector input a
- b_o  out  1  stimulus to selector input b
- y_i  in  1  selector output y, read back
- busy  out  1  high while a run is in progress
- done  out  1  single-cycle pulse when a run completes
- valid  out  1  exactly one candidate survived; sel_o meaningful
- err  out  1  no candidate survived; y_i matches none of the four functions
- sel_o  out  2  identified sel code

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- Reset values: a_o=0, b_o=0, busy=0, done=0, valid=0, err=0, sel_o=2'b00; FSM=IDLE; vec=0; cnt=0; mask=4'b1111.
- FSM states:
  - IDLE -> APPLY on start=1.
  - APPLY -> DECIDE after the vector-3 sample.
  - DECIDE -> IDLE after one cycle.
- Start acceptance (edge E0, start=1 in IDLE):
  - busy<=1, vec<=0, cnt<=0, mask<=4'b1111.
  - valid, err, sel_o cleared to 0.
- Stimulus in APPLY:
  - a_o=vec[0], b_o=vec[1]; vectors in order (a,b) = (0,0), (1,0), (0,1), (1,1).
  - cnt increments each edge.
  - On the edge where cnt==SETTLE, y_i is sampled, then cnt<=0 and vec<=vec+1.
  - Each vector occupies SETTLE+1 cycles.
- Elimination at each sample: clear mask[f] if y_i != f(a_o,b_o).
  - f0 = a&b
  - f1 = a|b
  - f2 = a^b
  - f3 = ~(a^b)
  - The clear is applied to the registered mask and includes the current sample.
- Timing:
  - Last sample lands on edge E0 + 4*(SETTLE+1); FSM enters DECIDE.
  - DECIDE edge (E0 + 4*(SETTLE+1) + 1): done<=1 for one cycle; busy<=0; a_o/b_o<=0; FSM -> IDLE.
- Result decode at the DECIDE edge:
  - Exactly one mask bit set: valid=1, err=0, sel_o=index of that bit.
  - Zero bits set: err=1, valid=0, sel_o=0.
  - More than one bit set cannot occur after a full sweep because the four truth tables are distinct.
- valid, err, sel_o hold until the next accepted start or reset.
- start while busy is ignored; runs are never restarted or queued.
- If start stays high, the next run is accepted on the edge after done rises; valid/err clear on that edge.
- rst mid-run: on the next edge all state returns to reset values; no done pulse is produced.
- Total latency from start edge to done high: 4*(SETTLE+1)+1 edges (9 for SETTLE=1, 5 for SETTLE=0).

Test Plan:
- Reset: assert rst 2 cycles with start=1 -> all outputs 0, busy stays 0 while rst is high.
- Loopback, sel=2'b10, SETTLE=1, 1-cycle start pulse:
  - (a_o,b_o) = 00, 10, 01, 11, each held 2 cycles.
  - done high exactly at edge 9 for 1 cycle; valid=1, sel_o=2'b10, err=0, busy low from edge 9.
- Loopback sweep: sel=00, 01, 11, 10, one run each, back to back -> sel_o matches each; valid=1, err=0 every run; done width 1 each.
- y_i tied 0 -> err=1, valid=0, sel_o=00 at edge 9. Repeat with y_i tied 1 -> err=1.
- start held high continuously, SETTLE=0, sel=01:
  - done pulses every 6 cycles (5-cycle run plus 1 re-accept cycle).
  - valid drops the edge after each done, reasserts with sel_o=01.
  - A start pulse during busy is ignored (no extra done).
- rst asserted at edge 4 of a run -> next edge: busy=0, a_o=b_o=0, no done. A fresh start then completes normally with correct sel_o.

Source files
------------

// File: rtl/fn_sw_4_ident.sv
// ============================================================================
// Module  : fn_sw_4_ident
// Brief   : Identifies which function (AND/OR/XOR/XNOR) a 4-function logic
//           selector implements by sweeping a/b and eliminating candidates.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fn_sw_4_ident #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       err,
    output logic [1:0] sel_o
);

    localparam logic [3:0] c_SETTLE_CNT = 4'(SETTLE);
    localparam logic [1:0] c_LAST_VEC   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_DECIDE = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic [3:0] r_mask;

    logic [3:0] w_truth;
    logic [3:0] w_mask_smp;
    logic       w_sample;
    logic [1:0] w_vec_nxt;
    logic       w_onehot;
    logic [1:0] w_idx;

    // Truth value of each candidate function for the vector currently driven.
    assign w_truth[0] = a_o & b_o;
    assign w_truth[1] = a_o | b_o;
    assign w_truth[2] = a_o ^ b_o;
    assign w_truth[3] = ~(a_o ^ b_o);

    assign w_mask_smp = r_mask & ~(w_truth ^ {4{y_i}});
    assign w_sample   = (r_cnt == c_SETTLE_CNT);
    assign w_vec_nxt  = r_vec + 2'd1;

    // The truth tables are distinct, so after a full sweep at most one bit survives.
    assign w_onehot = (r_mask != 4'b0000) && ((r_mask & (r_mask - 4'd1)) == 4'b0000);

    always_comb begin
        w_idx = 2'd0;
        case (r_mask)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= 2'd0;
            r_cnt   <= 4'd0;
            r_mask  <= 4'b1111;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
            sel_o   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_APPLY;
                        busy    <= 1'b1;
                        r_vec   <= 2'd0;
                        r_cnt   <= 4'd0;
                        r_mask  <= 4'b1111;
                        a_o     <= 1'b0;
                        b_o     <= 1'b0;
                        valid   <= 1'b0;
                        err     <= 1'b0;
                        sel_o   <= 2'b00;
                    end
                end
                S_APPLY: begin
                    if (w_sample) begin
                        // Stimulus advances on the same edge that samples y_i,
                        // keeping a_o/b_o aligned with r_vec.
                        r_mask <= w_mask_smp;
                        r_cnt  <= 4'd0;
                        r_vec  <= w_vec_nxt;
                        a_o    <= w_vec_nxt[0];
                        b_o    <= w_vec_nxt[1];
                        if (r_vec == c_LAST_VEC) begin
                            r_state <= S_DECIDE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DECIDE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    a_o     <= 1'b0;
                    b_o     <= 1'b0;
                    valid   <= w_onehot;
                    err     <= (r_mask == 4'b0000);
                    sel_o   <= w_onehot ? w_idx : 2'b00;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fn_sw_4_ident.sv
// ============================================================================
// Module  : tb_fn_sw_4_ident
// Brief   : Scoreboard bench for fn_sw_4_ident with SETTLE=1 and SETTLE=0 DUTs
//           looped back through a behavioural 4-function selector.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fn_sw_4_ident;

    typedef struct {
        logic       v;
        logic       e;
        logic [1:0] s;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // DUT with SETTLE=1
    logic       rst1, start1, a1, b1, y1, busy1, done1, valid1, err1;
    logic [1:0] sel1;
    logic [2:0] mode1;
    // DUT with SETTLE=0
    logic       rst0, start0, a0, b0, y0, busy0, done0, valid0, err0;
    logic [1:0] sel0;
    logic [2:0] mode0;

    exp_t q1[$];
    exp_t q0[$];
    int   ndone1 = 0;
    int   ndone0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural selector; modes 4 and 5 tie y to 0 and 1.
    function automatic logic fsel(input logic [2:0] m, input logic a, input logic b);
        case (m)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y1 = fsel(mode1, a1, b1);
    assign y0 = fsel(mode0, a0, b0);

    fn_sw_4_ident #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a_o(a1), .b_o(b1), .y_i(y1),
        .busy(busy1), .done(done1), .valid(valid1), .err(err1), .sel_o(sel1)
    );

    fn_sw_4_ident #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .a_o(a0), .b_o(b0), .y_i(y0),
        .busy(busy0), .done(done0), .valid(valid0), .err(err0), .sel_o(sel0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitors pop the scoreboard whenever a DUT raises done.
    always @(negedge clk) begin
        if (!rst1 && done1 === 1'b1) begin
            ndone1++;
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                chk("dut1_done_cycle", cyc, x.t);
                chk("dut1_valid", valid1, x.v);
                chk("dut1_err", err1, x.e);
                chk("dut1_sel", sel1, x.s);
                chk("dut1_busy_at_done", busy1, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst0 && done0 === 1'b1) begin
            ndone0++;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = q0.pop_front();
                chk("dut0_done_cycle", cyc, x.t);
                chk("dut0_valid", valid0, x.v);
                chk("dut0_err", err0, x.e);
                chk("dut0_sel", sel0, x.s);
            end
        end
    end

    function automatic exp_t mk_exp(input logic [2:0] m, input int t);
        exp_t x;
        x.v = (m < 3'd4);
        x.e = (m >= 3'd4);
        x.s = (m < 3'd4) ? m[1:0] : 2'b00;
        x.t = t;
        return x;
    endfunction

    // Called at a negedge; returns 1ns after the accepting edge.
    task automatic start_run1(input logic [2:0] m, input logic expect_done, output int e0);
        mode1  = m;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        e0     = cyc;
        start1 = 1'b0;
        if (expect_done) q1.push_back(mk_exp(m, e0 + 9));
    endtask

    task automatic wait_done1(input string tag);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) return;
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_done0(input string tag);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) return;
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int e0;
        int snap;
        logic [2:0] sweep [4];
        sweep[0] = 3'd0; sweep[1] = 3'd1; sweep[2] = 3'd3; sweep[3] = 3'd2;

        rst1 = 1'b1; start1 = 1'b1; mode1 = 3'd2;
        rst0 = 1'b1; start0 = 1'b1; mode0 = 3'd1;

        // Reset with start held high.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_busy1", busy1, 0);
            chk("rst_outs1", {a1, b1, done1, valid1, err1, sel1}, 0);
            chk("rst_busy0", busy0, 0);
            chk("rst_outs0", {a0, b0, done0, valid0, err0, sel0}, 0);
        end
        rst1 = 1'b0; start1 = 1'b0;
        rst0 = 1'b0; start0 = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback sel=10 with stimulus sequence checks.
        start_run1(3'd2, 1'b1, e0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("vec_a", a1, (k / 2) % 2);
            chk("vec_b", b1, (k / 2) / 2);
            chk("vec_busy", busy1, 1);
        end
        wait_done1("loop10");
        @(negedge clk);
        chk("done_width", done1, 0);
        chk("hold_valid", valid1, 1);
        chk("hold_sel", sel1, 2);

        // Back-to-back sweep.
        for (int i = 0; i < 4; i++) begin
            start_run1(sweep[i], 1'b1, e0);
            wait_done1("sweep");
        end
        @(negedge clk);

        // y tied low, then tied high.
        start_run1(3'd4, 1'b1, e0);
        wait_done1("tie0");
        start_run1(3'd5, 1'b1, e0);
        wait_done1("tie1");
        repeat (3) @(negedge clk);
        chk("err_hold", err1, 1);
        chk("valid_hold_low", valid1, 0);

        // Reset mid-run, sampled on edge 4 of the run.
        start_run1(3'd2, 1'b0, e0);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 rst1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy1, 0);
        chk("midrst_ab", {a1, b1}, 0);
        chk("midrst_flags", {done1, valid1, err1}, 0);
        rst1 = 1'b0;
        snap = ndone1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", ndone1 - snap, 0);
        start_run1(3'd3, 1'b1, e0);
        wait_done1("after_rst");

        // SETTLE=0: start held continuously, sel=01.
        @(negedge clk);
        mode0  = 3'd1;
        start0 = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        for (int i = 0; i < 4; i++) q0.push_back(mk_exp(3'd1, e0 + 5 + 6 * i));
        for (int i = 0; i < 3; i++) begin
            wait_done0("held");
            @(negedge clk);
            chk("held_valid_drop", valid0, 0);
            chk("held_busy_again", busy0, 1);
        end
        start0 = 1'b0;
        wait_done0("held_last");
        @(negedge clk);
        chk("held_final_valid", valid0, 1);
        chk("held_final_sel", sel0, 1);
        chk("held_final_busy", busy0, 0);

        // Start pulse during busy is ignored.
        mode0  = 3'd3;
        start0 = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        start0 = 1'b0;
        q0.push_back(mk_exp(3'd3, e0 + 5));
        snap = ndone0;
        @(negedge clk); @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_start_ignored", ndone0 - snap, 1);

        repeat (2) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
